// File: rtl/bus_mem_responder.sv
// -----------------------------------------------------------------------------
// bus_mem_responder
//
// Memory-side responder for the CPU system bus. Backs a word-addressed RAM and
// serves line-sized read bursts and accepts line-sized write bursts. Lets the
// pipeline run in simulation without an external memory model.
//
// One transaction is outstanding at a time. Bursts are critical-word-first and
// wrap inside the line. A read's first beat appears LATENCY cycles after the
// address beat is accepted.
//
// Optional feature (macro BUS_MEM_RANGE_CHECK_EN):
//   defined   - word addresses >= DEPTH are out of range. Reads of such an
//               address return 64'hDEAD_BEEF_DEAD_BEEF and writes are dropped.
//               Handshake timing is unchanged.
//   undefined - the word address wraps modulo DEPTH.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   bus_reqcyc   in   request beat valid
//   bus_reqack   out  request beat accepted this cycle (combinational)
//   bus_req      in   byte address on the first beat, write data on later beats
//   bus_reqtag   in   tag, sampled on the address beat; MSB = 1 read, 0 write
//   bus_respcyc  out  response beat valid
//   bus_respack  in   initiator consumes the current response beat
//   bus_resp     out  read data
//   bus_resptag  out  tag captured from the read request
// -----------------------------------------------------------------------------
module bus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8,
    parameter int DEPTH          = 4096,
    parameter int LATENCY        = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    output logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respcyc,
    input  logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    localparam int AW = $clog2(DEPTH);   // word index width
    localparam int BW = $clog2(BEATS);   // beat counter width
    localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LAT,
        RDATA,
        WDATA
    } state_t;

    state_t              state_q, state_d;
    logic [LW-1:0]       lat_q, lat_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [BUS_TAG_WIDTH-1:0] tag_q, tag_d;
`ifdef BUS_MEM_RANGE_CHECK_EN
    logic                oor_q, oor_d;
`endif

    logic [BUS_DATA_WIDTH-1:0] mem [DEPTH];

    logic          req_xfer;
    logic          resp_xfer;
    logic          last_beat;
    logic          mem_we;
    logic [BW-1:0] beat_off;
    logic [AW-1:0] beat_addr;

    // Handshake. Held off during reset so nothing is accepted while the
    // state register is being forced.
    assign bus_reqack = reset && bus_reqcyc && (state_q == IDLE || state_q == WDATA);
    assign req_xfer   = bus_reqcyc && bus_reqack;
    assign resp_xfer  = bus_respcyc && bus_respack;
    assign last_beat  = (beat_q == BW'(BEATS - 1));

    // Critical-word-first: the offset inside the line wraps, the line base
    // stays fixed.
    assign beat_off  = addr_q[BW-1:0] + beat_q;
    assign beat_addr = {addr_q[AW-1:BW], beat_off};

    // Outputs are decoded from registered state, so they are stable from the
    // start of each cycle until the transfer edge.
    assign bus_respcyc = (state_q == RDATA);
    assign bus_resptag = bus_respcyc ? tag_q : '0;

    always_comb begin
        bus_resp = '0;
        if (bus_respcyc) begin
`ifdef BUS_MEM_RANGE_CHECK_EN
            bus_resp = oor_q ? BUS_DATA_WIDTH'(64'hDEAD_BEEF_DEAD_BEEF) : mem[beat_addr];
`else
            bus_resp = mem[beat_addr];
`endif
        end
    end

`ifdef BUS_MEM_RANGE_CHECK_EN
    assign mem_we = req_xfer && (state_q == WDATA) && !oor_q;
`else
    assign mem_we = req_xfer && (state_q == WDATA);
`endif

    // Next-state logic.
    always_comb begin
        // NOTE: every signal gets its hold value first; any path that skipped
        // an assignment would otherwise infer a latch.
        state_d = state_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        tag_d   = tag_q;
`ifdef BUS_MEM_RANGE_CHECK_EN
        oor_d   = oor_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_xfer) begin
                    addr_d = bus_req[3 +: AW];
                    beat_d = '0;
`ifdef BUS_MEM_RANGE_CHECK_EN
                    oor_d  = |bus_req[BUS_DATA_WIDTH-1:3+AW];
`endif
                    if (bus_reqtag[BUS_TAG_WIDTH-1]) begin
                        tag_d   = bus_reqtag;
                        lat_d   = LW'(LATENCY - 1);
                        state_d = LAT;
                    end else begin
                        state_d = WDATA;
                    end
                end
            end
            LAT: begin
                if (lat_q == '0) begin
                    state_d = RDATA;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            RDATA: begin
                // The beat repeats for as long as the initiator stalls.
                if (resp_xfer) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            WDATA: begin
                if (req_xfer) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
            addr_q  <= '0;
            tag_q   <= '0;
`ifdef BUS_MEM_RANGE_CHECK_EN
            oor_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            tag_q   <= tag_d;
`ifdef BUS_MEM_RANGE_CHECK_EN
            oor_q   <= oor_d;
`endif
        end
    end

    // NOTE: the RAM array is deliberately not reset; contents survive reset
    // and a reset port on a memory would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[beat_addr] <= bus_req;
        end
    end

endmodule

// File: tb/tb_bus_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_bus_mem_responder
//
// Directed bench for bus_mem_responder: fills three lines with known data,
// aborts a read with reset, then replays a table of read bursts (aligned,
// wrapped, backpressured, busy-request, out-of-range address) against
// hand-computed beat data.
// -----------------------------------------------------------------------------
module tb_bus_mem_responder;

    localparam int LATENCY = 4;

    typedef logic [7:0][63:0] line_t;

    typedef struct {
        logic [63:0] addr;
        logic [12:0] tag;
        line_t       exp;
        int          hold_beat;   // beat to stall for 5 cycles, -1 for none
        bit          busy;        // keep a request pending through the burst
    } rd_vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bus_reqcyc = 1'b0;
    logic        bus_reqack;
    logic [63:0] bus_req = '0;
    logic [12:0] bus_reqtag = '0;
    logic        bus_respcyc;
    logic        bus_respack = 1'b0;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;

    int total = 0;
    int bad   = 0;

    rd_vec_t vecs [6];

    always #5 clk = ~clk;

    bus_mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .bus_reqcyc (bus_reqcyc),
        .bus_reqack (bus_reqack),
        .bus_req    (bus_req),
        .bus_reqtag (bus_reqtag),
        .bus_respcyc(bus_respcyc),
        .bus_respack(bus_respack),
        .bus_resp   (bus_resp),
        .bus_resptag(bus_resptag)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic line_t mk8(input logic [63:0] a0, a1, a2, a3, a4, a5, a6, a7);
        line_t l;
        l[0] = a0; l[1] = a1; l[2] = a2; l[3] = a3;
        l[4] = a4; l[5] = a5; l[6] = a6; l[7] = a7;
        return l;
    endfunction

    // Address beat then 8 data beats; beat i lands at data[i].
    task automatic do_write(input logic [63:0] addr, input logic [12:0] tag, input line_t data);
        int n;
        @(negedge clk);
        bus_req    = addr;
        bus_reqtag = tag;
        bus_reqcyc = 1'b1;
        #1;
        n = 0;
        while (!bus_reqack && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check("wr_accept", bus_reqack, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus_req = data[i];
            #1;
            check("wr_beat_ack", bus_reqack, 1);
        end
        @(negedge clk);
        bus_reqcyc = 1'b0;
        #1;
        check("wr_no_resp", bus_respcyc, 0);
    endtask

    task automatic do_read(input rd_vec_t v);
        int n;
        @(negedge clk);
        bus_req     = v.addr;
        bus_reqtag  = v.tag;
        bus_reqcyc  = 1'b1;
        bus_respack = 1'b0;
        #1;
        n = 0;
        while (!bus_reqack && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check("rd_accept", bus_reqack, 1);
        @(negedge clk);                      // accepting edge is behind us
        if (!v.busy) bus_reqcyc = 1'b0;
        #1;
        n = 0;
        while (!bus_respcyc && n < 50) begin
            if (v.busy) check("busy_ack_lat", bus_reqack, 0);
            @(negedge clk); #1; n++;
        end
        check("rd_latency", n, LATENCY);
        for (int i = 0; i < 8; i++) begin
            if (i == v.hold_beat) begin
                for (int h = 0; h < 5; h++) begin
                    bus_respack = 1'b0;
                    #1;
                    check("hold_data", bus_resp, v.exp[i]);
                    check("hold_tag", bus_resptag, v.tag);
                    @(negedge clk);
                end
            end
            bus_respack = 1'b1;
            #1;
            check("rd_valid", bus_respcyc, 1);
            check("rd_data", bus_resp, v.exp[i]);
            check("rd_tag", bus_resptag, v.tag);
            if (v.busy) check("busy_ack_rd", bus_reqack, 0);
            @(negedge clk);
        end
        bus_respack = 1'b0;
        #1;
        check("rd_end", bus_respcyc, 0);
        if (v.busy) begin
            // First IDLE cycle accepts; withdraw before the edge.
            check("busy_ack_idle", bus_reqack, 1);
            bus_reqcyc = 1'b0;
        end
    endtask

    initial begin
        vecs[0] = '{64'h100, 13'h1042, mk8(1, 2, 3, 4, 5, 6, 7, 8), -1, 1'b0};
        vecs[1] = '{64'h128, 13'h1abc, mk8(6, 7, 8, 1, 2, 3, 4, 5), -1, 1'b0};
        vecs[2] = '{64'h13F, 13'h1fff, mk8(8, 1, 2, 3, 4, 5, 6, 7), 2, 1'b0};
        vecs[3] = '{64'h01C, 13'h1003,
                    mk8(64'h103, 64'h104, 64'h105, 64'h106, 64'h107, 64'h100, 64'h101, 64'h102),
                    -1, 1'b1};
        vecs[4] = '{64'h200, 13'h1555,
                    mk8(64'h205, 64'h206, 64'h207, 64'h200, 64'h201, 64'h202, 64'h203, 64'h204),
                    -1, 1'b0};
`ifdef BUS_MEM_RANGE_CHECK_EN
        vecs[5] = '{64'h8000, 13'h1001,
                    mk8(64'hDEADBEEFDEADBEEF, 64'hDEADBEEFDEADBEEF, 64'hDEADBEEFDEADBEEF,
                        64'hDEADBEEFDEADBEEF, 64'hDEADBEEFDEADBEEF, 64'hDEADBEEFDEADBEEF,
                        64'hDEADBEEFDEADBEEF, 64'hDEADBEEFDEADBEEF),
                    -1, 1'b0};
`else
        vecs[5] = '{64'h8000, 13'h1001,
                    mk8(64'h100, 64'h101, 64'h102, 64'h103, 64'h104, 64'h105, 64'h106, 64'h107),
                    -1, 1'b0};
`endif

        // Reset state, with a request pending.
        bus_reqcyc = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_respcyc", bus_respcyc, 0);
        check("rst_resp", bus_resp, 0);
        check("rst_resptag", bus_resptag, 0);
        check("rst_reqack", bus_reqack, 0);
        bus_reqcyc = 1'b0;
        reset = 1'b1;

        // Fill: line 0, line at word 32, and line 64 written starting mid-line.
        do_write(64'h000, 13'h0042,
                 mk8(64'h100, 64'h101, 64'h102, 64'h103, 64'h104, 64'h105, 64'h106, 64'h107));
        do_write(64'h100, 13'h0042, mk8(1, 2, 3, 4, 5, 6, 7, 8));
        do_write(64'h218, 13'h0007,
                 mk8(64'h200, 64'h201, 64'h202, 64'h203, 64'h204, 64'h205, 64'h206, 64'h207));

        // Reset for 3 cycles in the middle of a read burst.
        @(negedge clk);
        bus_req    = 64'h100;
        bus_reqtag = 13'h1042;
        bus_reqcyc = 1'b1;
        #1;
        check("mid_accept", bus_reqack, 1);
        @(negedge clk);
        bus_reqcyc = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("mid_in_rdata", bus_respcyc, 1);
        reset      = 1'b0;
        bus_reqcyc = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("mid_rst_respcyc", bus_respcyc, 0);
            check("mid_rst_resp", bus_resp, 0);
            check("mid_rst_resptag", bus_resptag, 0);
            check("mid_rst_reqack", bus_reqack, 0);
            @(negedge clk);
        end
        reset      = 1'b1;
        bus_reqcyc = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("no_resume", bus_respcyc, 0);

        for (int i = 0; i < 6; i++) begin
            do_read(vecs[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so a stuck run still reports.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Memory-side responder for the CPU system bus (reqcyc/reqack/req/reqtag and respcyc/respack/resp/resptag); the other end of the initiator that issues instruction fetches and data accesses.
- Backs a word-addressed RAM; serves line-sized read bursts and accepts line-sized write bursts.
- Lets the pipeline run standalone in simulation and block-level benches without the external memory model.

Parameters:
- BUS_DATA_WIDTH, 64, width of bus_req / bus_resp; one beat is one 64-bit word.
- BUS_TAG_WIDTH, 13, width of the tag buses; tag[12] is the direction (1 = read, 0 = write) and tag[11:0] is opaque and echoed back.
- BEATS, 8, beats per burst (64-byte line); power of two.
- DEPTH, 4096, RAM depth in words; power of two and a multiple of BEATS.
- LATENCY, 4, cycles from read acceptance to the first response beat; must be 1 or more.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- bus_reqcyc  input  1  request beat valid.
- bus_reqack  output  1  request beat accepted this cycle.
- bus_req  input  BUS_DATA_WIDTH  byte address on the first beat; write data on later beats.
- bus_reqtag  input  BUS_TAG_WIDTH  transaction tag, sampled on the address beat.
- bus_respcyc  output  1  response beat valid.
- bus_respack  input  1  initiator consumes the current response beat.
- bus_resp  output  BUS_DATA_WIDTH  read data.
- bus_resptag  output  BUS_TAG_WIDTH  tag captured from the request.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; bus_respcyc = 0; bus_resp = 0; bus_resptag = 0.
  - Latency counter, beat counter and captured address/tag all clear.
  - bus_reqack = 0 while reset is low.
  - RAM contents are not cleared.
  - Reset asserted mid-burst aborts the transaction; no partial response is resumed after release.
- A request beat transfers on a rising edge where bus_reqcyc && bus_reqack.
  - bus_reqack = bus_reqcyc && (state == IDLE || state == WDATA).
  - bus_reqack is combinational from state and bus_reqcyc.
- A response beat transfers on a rising edge where bus_respcyc && bus_respack.
  - bus_resp and bus_resptag hold stable until that edge.
- Only one transaction is outstanding. bus_reqcyc in LAT or RDATA is ignored: bus_reqack stays 0 and no state changes.
- Word index w = bus_req[63:3] mod DEPTH; bits [2:0] are ignored. Line base b = w with its low log2(BEATS) bits cleared.
- Burst order is critical-word-first with wrap inside the line: beat i targets b + ((w + i) mod BEATS).
  - Example, BEATS = 8, w = 13: words 13, 14, 15, 8, 9, 10, 11, 12.
- States:
  - IDLE:
    - Address beat with tag[12] = 1: capture address and tag, latency counter = LATENCY-1, go to LAT.
    - Address beat with tag[12] = 0: capture address, beat counter = 0, go to WDATA.
  - LAT: counter decrements each cycle; at 0 go to RDATA. The first beat is visible in the cycle exactly LATENCY cycles after the accepting edge.
  - RDATA:
    - bus_respcyc = 1, bus_resp = RAM[beat target], bus_resptag = captured tag.
    - Beat counter advances only on a transfer; with bus_respack low the beat repeats indefinitely.
    - After the transfer of beat BEATS-1, bus_respcyc drops on the next cycle and state returns to IDLE.
  - WDATA:
    - Each transferred beat writes bus_req to RAM[beat target] at that edge.
    - After beat BEATS-1, return to IDLE. A write produces no response beats.
- Back-to-back: a new address beat may be accepted in the first IDLE cycle after a burst ends (zero-cycle turnaround).
- Read-after-write to the same line returns the newly written data.
- Beat counter is log2(BEATS) bits and wraps naturally; there is no over-count.

Optional Feature:
- Macro BUS_MEM_RANGE_CHECK_EN.
- Defined: an address with bus_req[63:3] >= DEPTH is out of range.
  - Out-of-range read beats return 64'hDEAD_BEEF_DEAD_BEEF.
  - Out-of-range write beats are dropped.
  - Handshake timing is unchanged.
- Undefined: the address wraps modulo DEPTH as described above.

Test Plan:
- Reset then idle: reset low for 3 cycles mid-read → bus_respcyc = 0, bus_resp = 0, bus_reqack = 0 during reset; the next read after release behaves normally.
- Write then read, tag 0x0042: write address 0x100 with data 0x1..0x8, then read address 0x100 with tag 0x1042 → first beat exactly 4 cycles after acceptance, beats 0x1..0x8, bus_resptag = 0x1042 on every beat.
- Wrap order: read address 0x128 (w = 37) → beats return words 37, 38, 39, 32, 33, 34, 35, 36.
- Backpressure: bus_respack low for 5 cycles on beat 2 → beat 2 data and tag held constant; 8 transfers total; IDLE one cycle after the last transfer.
- Busy ignore: bus_reqcyc asserted during LAT and RDATA → bus_reqack stays 0; the request is accepted in the first IDLE cycle.
- Range check: with BUS_MEM_RANGE_CHECK_EN defined, read address 0x8000 (DEPTH = 4096) → all beats 64'hDEAD_BEEF_DEAD_BEEF. Without the macro → data from word 0 upward.
